// File: rtl/spdif_subframe_sequencer.sv
// S/PDIF subframe sequencer: Z/X/Y order check, lock, 28 slot strobes.
// Define SPDIF_SEQ_ERRCNT_EN to build the saturating error counter.
module spdif_subframe_sequencer #(
  parameter int unsigned SLOT_CLKS        = 6,
  parameter int unsigned STROBE_OFFSET    = 4,
  parameter int unsigned TIMEOUT          = 400,
  parameter int unsigned FRAMES_PER_BLOCK = 192
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [2:0] i_flag,
  output logic       o_lock,
  output logic       o_channel,
  output logic       o_block_start,
  output logic [7:0] o_frame_idx,
  output logic       o_slot_strobe,
  output logic [4:0] o_slot_idx,
  output logic       o_subframe_done,
  output logic       o_error,
  output logic [7:0] o_err_count
);

  localparam logic [7:0]  LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);
  localparam logic [15:0] TMO_HIT    = 16'(TIMEOUT - 1);
  localparam logic [7:0]  OFS_LD     = 8'(STROBE_OFFSET - 1);
  localparam logic [7:0]  SLOT_LD    = 8'(SLOT_CLKS - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        en_q;
  logic        ev;
  logic        is_x, is_y, is_z;
  logic        exp_x, exp_y, exp_z;
  logic        match, early, tmo_hit;
  logic [7:0]  frame_q, frame_d;
  logic        chan_q, chan_d;
  logic        bs_q, bs_d;
  logic        err_q, err_d;
  logic        run_q, run_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  slot_q, slot_d;
  logic [4:0]  idx_q, idx_d;
  logic        stb_q, stb_d;
  logic        done_q, done_d;
  logic [15:0] tmo_q, tmo_d;

  assign ev = i_enable & ~en_q;

  always_comb begin
    is_x = 1'b0;
    is_y = 1'b0;
    is_z = 1'b0;
    unique case (i_flag)
      3'b001, 3'b110: is_x = 1'b1;
      3'b010, 3'b101: is_y = 1'b1;
      3'b100, 3'b011: is_z = 1'b1;
      default: ;
    endcase
  end

  // Expected preamble follows from the last accepted one.
  assign exp_y   = ~chan_q;
  assign exp_z   = chan_q & (frame_q == LAST_FRAME);
  assign exp_x   = chan_q & (frame_q != LAST_FRAME);
  assign match   = (is_x & exp_x) | (is_y & exp_y) | (is_z & exp_z);
  assign early   = run_q & (state_q == LOCKED);
  assign tmo_hit = (tmo_q == TMO_HIT);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= HUNT;
      en_q    <= 1'b0;
      frame_q <= '0;
      chan_q  <= 1'b0;
      bs_q    <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= i_enable;
      frame_q <= frame_d;
      chan_q  <= chan_d;
      bs_q    <= bs_d;
      err_q   <= err_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    chan_d  = chan_q;
    bs_d    = 1'b0;
    err_d   = 1'b0;
    if (ev) begin
      if (state_q == LOCKED && !early && match) begin
        if (is_x) begin
          frame_d = frame_q + 8'd1;
          chan_d  = 1'b0;
        end
        if (is_y) chan_d = 1'b1;
        if (is_z) begin
          frame_d = '0;
          chan_d  = 1'b0;
          bs_d    = 1'b1;
        end
      end else begin
        // A Z always (re)locks, even right after a violation.
        err_d = (state_q == LOCKED);
        if (is_z) begin
          state_d = LOCKED;
          frame_d = '0;
          chan_d  = 1'b0;
          bs_d    = 1'b1;
        end else begin
          state_d = HUNT;
        end
      end
    end else if (tmo_hit && state_q == LOCKED) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end
  end

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    slot_d = slot_q;
    idx_d  = idx_q;
    stb_d  = 1'b0;
    done_d = 1'b0;
    tmo_d  = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
    if (ev) begin
      run_d  = 1'b1;
      cnt_d  = OFS_LD;
      slot_d = 5'd4;
      tmo_d  = '0;
    end else if (run_q) begin
      if (cnt_q == 8'd0) begin
        stb_d  = 1'b1;
        idx_d  = slot_q;
        cnt_d  = SLOT_LD;
        slot_d = slot_q + 5'd1;
        if (slot_q == 5'd31) begin
          done_d = 1'b1;
          run_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    o_lock          = (state_q == LOCKED);
    o_channel       = chan_q;
    o_block_start   = bs_q;
    o_frame_idx     = frame_q;
    o_slot_strobe   = stb_q;
    o_slot_idx      = idx_q;
    o_subframe_done = done_q;
    o_error         = err_q;
  end

`ifdef SPDIF_SEQ_ERRCNT_EN
  logic [7:0] ecnt_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)
      ecnt_q <= '0;
    else if (err_d && ecnt_q != 8'hFF)
      ecnt_q <= ecnt_q + 8'd1;
  end

  assign o_err_count = ecnt_q;
`else
  assign o_err_count = 8'd0;
`endif

endmodule
